// File: rtl/rv32i_types.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_req_t   : one latched memory request (op, mask, address, write data)
// Struct field widths are fixed by ARB_ADDR_W / ARB_DATA_W. The arbiter's
// ADDR_W / DATA_W must not exceed them.
package rv32i_types;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} arb_state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [3:0]            wmask;
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive contended data-side wins.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : count one more contended D-side win (ignored at the limit)
//   clr        : clear (has priority over inc)
//   limit      : saturation value
//   at_limit   : count has reached limit
module arb_starve_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_limit
);
    logic [W-1:0] count;

    assign at_limit = (count == limit);

    always_ff @(posedge clk) begin
        if (!rst_n)                 count <= '0;
        else if (clr)               count <= '0;
        else if (inc && !at_limit)  count <= count + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port a, read-only) and
// the data side (port b, read/write). A grant is latched in IDLE and held on
// pmem_* until pmem_resp; the response is routed back combinationally.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   read_a, address_a                : fetch request
//   rdata_a, resp_a                  : fetch response
//   read_b, write, wmask, address_b,
//   wdata                            : data request
//   rdata_b, resp_b                  : data response
//   pmem_read/write/wmask/address/
//   wdata, pmem_rdata, pmem_resp     : shared memory port
// Build option: MEM_ARB_ROUND_ROBIN_EN makes contended grants alternate;
// otherwise the data side wins contention with a starvation counter
// forcing a fetch grant after STARVE_LIMIT consecutive contended D wins.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              resp_a,
    input  logic              read_b,
    input  logic              write,
    input  logic [3:0]        wmask,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_b,
    output logic              resp_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [3:0]        pmem_wmask,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    arb_state_t state;
    arb_req_t   req_q;
    logic       req_a, req_b, grant_a, grant_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = A, 1 = B

    always_comb begin
        req_a   = read_a;
        req_b   = read_b | write;
        // Contended: serve the side that did not win last time.
        grant_b = req_b & (!req_a | !last_grant);
        grant_a = req_a & !grant_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                                 last_grant <= 1'b0;
        else if (state == IDLE && grant_b)          last_grant <= 1'b1;
        else if (state == IDLE && grant_a)          last_grant <= 1'b0;
    end
`else
    logic at_limit, cnt_inc, cnt_clr;

    always_comb begin
        req_a   = read_a;
        req_b   = read_b | write;
        grant_a = req_a & (!req_b | at_limit);
        grant_b = req_b & !grant_a;
        // Only contended B wins count; any A grant resets the streak.
        cnt_inc = (state == IDLE) & grant_b & req_a;
        cnt_clr = (state == IDLE) & grant_a;
    end

    arb_starve_ctr #(.W(4)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .limit    (4'(STARVE_LIMIT)),
        .at_limit (at_limit)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_b) begin
                        // A simultaneous read+write is treated as a write.
                        req_q.read    <= read_b & ~write;
                        req_q.write   <= write;
                        req_q.wmask   <= wmask;
                        req_q.address <= ARB_ADDR_W'(address_b);
                        req_q.wdata   <= ARB_DATA_W'(wdata);
                        state         <= SERVE_B;
                    end else if (grant_a) begin
                        req_q.read    <= 1'b1;
                        req_q.write   <= 1'b0;
                        req_q.wmask   <= 4'h0;
                        req_q.address <= ARB_ADDR_W'(address_a);
                        req_q.wdata   <= '0;
                        state         <= SERVE_A;
                    end
                end
                SERVE_A, SERVE_B: begin
                    // Request inputs are not looked at here: drops don't abort.
                    if (pmem_resp) begin
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem_read    = req_q.read;
    assign pmem_write   = req_q.write;
    assign pmem_wmask   = req_q.wmask;
    assign pmem_address = req_q.address[ADDR_W-1:0];
    assign pmem_wdata   = req_q.wdata[DATA_W-1:0];

    assign resp_a  = (state == SERVE_A) & pmem_resp;
    assign resp_b  = (state == SERVE_B) & pmem_resp;
    assign rdata_a = pmem_rdata;
    assign rdata_b = pmem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change on the falling edge; outputs are checked on the falling edge
// (registered) or #1 after an input change (combinational response path).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_a, read_b, write;
    logic [31:0] address_a, address_b, wdata, pmem_rdata;
    logic [3:0]  wmask;
    logic        pmem_resp;
    logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
    logic        resp_a, resp_b, pmem_read, pmem_write;
    logic [3:0]  pmem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .address_a(address_a), .rdata_a(rdata_a), .resp_a(resp_a),
        .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
        .wdata(wdata), .rdata_b(rdata_b), .resp_b(resp_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        read_a = 0; read_b = 0; write = 0; wmask = 0; pmem_resp = 0;
        address_a = 0; address_b = 0; wdata = 0; pmem_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Expected winner of the i-th contended grant: 1 = A, 0 = B.
    function automatic logic exp_a(input int i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    initial begin
        int ngrant;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_pmem_read",  pmem_read,  0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr",  pmem_address, 0);
        chk("rst_pmem_wmask", pmem_wmask, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_resp_a",     resp_a, 0);
        chk("rst_resp_b",     resp_b, 0);

        // 1: fetch read at 0x60, response 3 cycles after grant
        read_a = 1; address_a = 32'h60;
        @(negedge clk);
        chk("t1_pmem_read", pmem_read, 1);
        chk("t1_pmem_addr", pmem_address, 32'h60);
        chk("t1_pmem_write", pmem_write, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t1_hold_read", pmem_read, 1);
            chk("t1_no_resp_a", resp_a, 0);
        end
        pmem_resp = 1; pmem_rdata = 32'hDEADBEEF; #1;
        chk("t1_resp_a",  resp_a, 1);
        chk("t1_rdata_a", rdata_a, 32'hDEADBEEF);
        chk("t1_resp_b",  resp_b, 0);
        @(negedge clk);
        read_a = 0; pmem_resp = 0;
        chk("t1_idle_read", pmem_read, 0);
        @(negedge clk);
        chk("t1_no_regrant", pmem_read, 0);

        // 2: write, address_b changes mid-transaction
        write = 1; address_b = 32'h100; wdata = 32'h12345678; wmask = 4'hC;
        @(negedge clk);
        chk("t2_pmem_write", pmem_write, 1);
        chk("t2_pmem_read",  pmem_read, 0);
        chk("t2_pmem_addr",  pmem_address, 32'h100);
        chk("t2_pmem_wmask", pmem_wmask, 4'hC);
        chk("t2_pmem_wdata", pmem_wdata, 32'h12345678);
        address_b = 32'h200; wdata = 32'h0; wmask = 4'h3;
        @(negedge clk);
        chk("t2_addr_stable",  pmem_address, 32'h100);
        chk("t2_wmask_stable", pmem_wmask, 4'hC);
        pmem_resp = 1; #1;
        chk("t2_resp_b", resp_b, 1);
        chk("t2_resp_a", resp_a, 0);
        @(negedge clk);
        write = 0; pmem_resp = 0; #1;
        chk("t2_resp_b_once", resp_b, 0);
        chk("t2_idle_write", pmem_write, 0);
        @(negedge clk);

        // 4: read_b and write together -> write wins
        read_b = 1; write = 1; address_b = 32'h40;
        @(negedge clk);
        chk("t4_pmem_write", pmem_write, 1);
        chk("t4_pmem_read",  pmem_read, 0);
        pmem_resp = 1;
        @(negedge clk);
        read_b = 0; write = 0; pmem_resp = 0;
        @(negedge clk);

        // 5: pmem_resp in IDLE is ignored
        pmem_resp = 1; #1;
        chk("t5_resp_a", resp_a, 0);
        chk("t5_resp_b", resp_b, 0);
        @(negedge clk);
        chk("t5_idle_read",  pmem_read, 0);
        chk("t5_idle_write", pmem_write, 0);
        pmem_resp = 0;

        // 3: both sides held, pmem_resp always high; grant order from reset
        do_reset();
        read_a = 1; address_a = 32'hA0; read_b = 1; address_b = 32'hB0;
        pmem_resp = 1;
        ngrant = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_resp_exclusive", {63'b0, resp_a & resp_b}, 0);
            if (pmem_read) begin
                chk($sformatf("t3_grant%0d", ngrant), pmem_address,
                    exp_a(ngrant) ? 32'hA0 : 32'hB0);
                ngrant++;
            end
        end
        chk("t3_grant_count", ngrant, 10);
        read_a = 0; read_b = 0; pmem_resp = 0;
        repeat (2) @(negedge clk);

        // 6: reset during SERVE_B, stale pmem_resp ignored
        write = 1; address_b = 32'h300; wdata = 32'h55AA55AA; wmask = 4'hF;
        @(negedge clk);
        chk("t6_pmem_write", pmem_write, 1);
        rst_n = 0;
        @(negedge clk);
        write = 0;
        chk("t6_rst_write", pmem_write, 0);
        chk("t6_rst_addr",  pmem_address, 0);
        chk("t6_rst_wdata", pmem_wdata, 0);
        chk("t6_rst_wmask", pmem_wmask, 0);
        rst_n = 1; pmem_resp = 1; #1;
        chk("t6_stale_resp_b", resp_b, 0);
        chk("t6_stale_resp_a", resp_a, 0);
        @(negedge clk);
        pmem_resp = 0;
        chk("t6_idle_read",  pmem_read, 0);
        chk("t6_idle_write", pmem_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
